// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
// -----------------
// Generates the x/y/z select inputs of a 3-to-8 line decoder (x = MSB).
// A start pulse launches a sweep over the enabled channels of ch_mask in
// ascending order. Each channel is held for max(dwell,1) cycles. At the end
// of a sweep the controller either stops (single mode) or wraps back to the
// lowest enabled channel (continuous mode). A stop request aborts the sweep.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       sweep request, only looked at while idle
//   stop        abort request, only looked at while busy
//   continuous  wrap after the last channel (captured at start)
//   ch_mask     channel enables, bit i = channel i (captured at start)
//   dwell       cycles per channel, 0 behaves as 1 (captured at start)
//   x, y, z     decoder select bits, all 0 while sel_valid is low
//   sel_valid   x/y/z address a live channel
//   ch_done     high in the final dwell cycle of each channel
//   busy        sweep in progress
//   done        one-cycle pulse: sweep finished, aborted, or empty-mask start
//   sweep_cnt   completed-sweep counter, saturating (only with the
//               DECODER_SCAN_STATUS_EN macro defined)
//
// Optional feature macro: DECODER_SCAN_STATUS_EN
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               x,
  output logic               y,
  output logic               z,
  output logic               sel_valid,
  output logic               ch_done,
  output logic               busy,
  output logic               done
`ifdef DECODER_SCAN_STATUS_EN
  ,
  output logic [CNT_W-1:0]   sweep_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DWELL  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         ch, ch_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [7:0]         mask_q, mask_nxt;
  logic               cont_q, cont_nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt;
  logic [3:0]         nxt;
  logic               last_cycle;

  // Elaboration-time sanity check of the configuration.
  if (DWELL_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("decoder_scan_ctrl: DWELL_W and CNT_W must be at least 1");
  end

  // A programmed dwell of zero still holds the channel for one cycle.
  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  // Lowest set bit of m (0 when m is empty; callers guard that case).
  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next enabled channel strictly above c: {found, index}.
  function automatic logic [3:0] next_idx(input logic [7:0] m, input logic [2:0] c);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign nxt        = next_idx(mask_q, ch);
  assign last_cycle = (state == DWELL) && (cnt == DWELL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= 3'd0;
      cnt     <= '0;
      mask_q  <= 8'd0;
      cont_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      cnt     <= cnt_nxt;
      mask_q  <= mask_nxt;
      cont_q  <= cont_nxt;
      dwell_q <= dwell_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    cnt_nxt   = cnt;
    mask_nxt  = mask_q;
    cont_nxt  = cont_q;
    dwell_nxt = dwell_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          mask_nxt  = ch_mask;
          cont_nxt  = continuous;
          dwell_nxt = dwell;
          if (ch_mask != 8'd0) begin
            state_nxt = DWELL;
            ch_nxt    = lowest_idx(ch_mask);
            cnt_nxt   = eff_dwell(dwell);
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      DWELL: begin
        // Abort wins over any channel advance.
        if (stop) begin
          state_nxt = FINISH;
        end else if (last_cycle) begin
          if (nxt[3]) begin
            ch_nxt  = nxt[2:0];
            cnt_nxt = eff_dwell(dwell_q);
          end else if (cont_q) begin
            ch_nxt  = lowest_idx(mask_q);
            cnt_nxt = eff_dwell(dwell_q);
          end else begin
            state_nxt = FINISH;
          end
        end else begin
          cnt_nxt = cnt - DWELL_W'(1);
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sel_valid   = (state == DWELL);
  assign busy        = (state == DWELL);
  assign done        = (state == FINISH);
  assign {x, y, z}   = sel_valid ? ch : 3'd0;
  // Suppressed when a stop lands on the final dwell cycle.
  assign ch_done     = last_cycle && !stop;

`ifdef DECODER_SCAN_STATUS_EN
  logic sweep_inc;

  // A sweep completes when the last enabled channel finishes its dwell
  // without an abort, whether it then wraps or finishes.
  assign sweep_inc = last_cycle && !stop && !nxt[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      sweep_cnt <= '0;
    end else if (sweep_inc && (sweep_cnt != '1)) begin
      sweep_cnt <= sweep_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Testbench for decoder_scan_ctrl: directed scenarios with literal
// expectations plus free-running random stimulus, all checked every cycle
// against a behavioural model based on elapsed cycles since start.
module tb_decoder_scan_ctrl;
  localparam int DWELL_W = 8;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start, stop, continuous;
  logic [7:0] ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic x, y, z, sel_valid, ch_done, busy, done;
`ifdef DECODER_SCAN_STATUS_EN
  logic [CNT_W-1:0] sweep_cnt;
`endif

  int checks = 0;
  int errors = 0;

  decoder_scan_ctrl #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .continuous(continuous), .ch_mask(ch_mask), .dwell(dwell),
    .x(x), .y(y), .z(z), .sel_valid(sel_valid), .ch_done(ch_done),
    .busy(busy), .done(done)
`ifdef DECODER_SCAN_STATUS_EN
    , .sweep_cnt(sweep_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ph: 0 idle, 1 sweeping, 2 finish cycle. k counts cycles since accept
  // (k=1 is the first select cycle); the channel shown is the
  // ((k-1)/D mod n)-th enabled channel.
  int ph = 0, k = 0, D = 1, n = 0, msweep = 0;
  int E[8];
  bit mcont = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; k = 0; D = 1; n = 0; mcont = 0; msweep = 0;
    end else begin
      case (ph)
        0: if (start) begin
          n = 0;
          for (int i = 0; i < 8; i++) if (ch_mask[i]) begin E[n] = i; n++; end
          D = (dwell == 0) ? 1 : int'(dwell);
          mcont = continuous;
          msweep = 0;
          k = 1;
          ph = (n == 0) ? 2 : 1;
        end
        1: begin
          if (stop) ph = 2;
          else if (((k - 1) % D) == D - 1 && (((k - 1) / D) % n) == n - 1) begin
            if (msweep < (1 << CNT_W) - 1) msweep++;
            if (mcont) k++; else ph = 2;
          end else k++;
        end
        default: ph = 0;
      endcase
    end
  end

  // Single compare process: every falling edge.
  always @(negedge clk) begin
    int exp_v, act_v, ech, ecd;
    ech = 0; ecd = 0;
    if (ph == 1) begin
      ech = E[((k - 1) / D) % n];
      ecd = ((((k - 1) % D) == D - 1) && !stop) ? 1 : 0;
    end
    exp_v = {(ph == 1) ? 1'b1 : 1'b0, 3'(ech), ecd[0], (ph == 1) ? 1'b1 : 1'b0, (ph == 2) ? 1'b1 : 1'b0};
    act_v = {sel_valid, x, y, z, ch_done, busy, done};
    chk("cycle{sv,xyz,cd,busy,done}", act_v, exp_v);
`ifdef DECODER_SCAN_STATUS_EN
    chk("cycle_sweep_cnt", int'(sweep_cnt), msweep);
`endif
  end

  task automatic step(input int cnt = 1);
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  function automatic int sel();
    return int'({x, y, z});
  endfunction

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; continuous = 0; ch_mask = 8'h00; dwell = '0;
    step(3);
    chk("reset_outputs", int'({sel_valid, x, y, z, ch_done, busy, done}), 0);
    rst_n = 1'b1;
    step(2);

    // Full sweep, dwell 2, with ignored start/mask change mid-sweep.
    ch_mask = 8'hFF; dwell = 2; continuous = 0; start = 1;
    step(); start = 0;                               // T+1
    chk("full_t1_sel", sel(), 0);
    chk("full_t1_busy", int'(busy), 1);
    chk("full_t1_chdone", int'(ch_done), 0);
    step();                                          // T+2
    chk("full_t2_chdone", int'(ch_done), 1);
    step(3);                                         // T+5
    start = 1; ch_mask = 8'h0F; dwell = 7;
    step(); start = 0;                               // T+6
    chk("full_t6_sel", sel(), 2);
    step(10);                                        // T+16
    chk("full_t16_sel", sel(), 7);
    chk("full_t16_chdone", int'(ch_done), 1);
    step();                                          // T+17
    chk("full_t17_done", int'(done), 1);
    chk("full_t17_busy", int'(busy), 0);
    start = 1; ch_mask = 8'hFF;                      // start in FINISH: ignored
    step(); start = 0;                               // T+18
    chk("finish_start_ignored", int'({busy, sel_valid, done}), 0);
    step(2);

    // Sparse mask, dwell 0.
    ch_mask = 8'b1010_0100; dwell = 0; start = 1;
    step(); start = 0;
    chk("sparse_t1_sel", sel(), 2);
    chk("sparse_t1_chdone", int'(ch_done), 1);
    step();
    chk("sparse_t2_sel", sel(), 5);
    step();
    chk("sparse_t3_sel", sel(), 7);
    chk("sparse_t3_chdone", int'(ch_done), 1);
    step();
    chk("sparse_t4_done", int'(done), 1);
    step(2);

    // Continuous with stop at T+10.
    ch_mask = 8'h81; dwell = 3; continuous = 1; start = 1;
    step(); start = 0;
    chk("cont_t1_sel", sel(), 0);
    step(3);
    chk("cont_t4_sel", sel(), 7);
    step(3);
    chk("cont_t7_sel", sel(), 0);
    step(3);                                         // T+10
    stop = 1; #1;
    chk("cont_t10_sel", sel(), 7);
    chk("cont_t10_chdone", int'(ch_done), 0);
    step(); stop = 0;                                // T+11
    chk("cont_t11_done", int'(done), 1);
`ifdef DECODER_SCAN_STATUS_EN
    chk("cont_t11_sweep_cnt", int'(sweep_cnt), 1);
`endif
    continuous = 0;
    step(2);

    // Empty mask.
    ch_mask = 8'h00; start = 1;
    step(); start = 0;
    chk("empty_t1_done", int'(done), 1);
    chk("empty_t1_busy_sv", int'({busy, sel_valid}), 0);
    step();
    chk("empty_t2_done", int'(done), 0);
    step(2);

    // Async reset mid-dwell on channel 5 (dwell 4: channel 5 at T+21..T+24).
    ch_mask = 8'hFF; dwell = 4; start = 1;
    step(); start = 0;
    step(21);                                        // T+22
    chk("areset_pre_sel", sel(), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_outputs", int'({sel_valid, x, y, z, ch_done, busy, done}), 0);
    step(2);
    #2 rst_n = 1'b1;
    step(4);
    chk("areset_idle_after", int'({sel_valid, busy, done}), 0);

    // Free-running random stimulus.
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 5) == 0);
      stop       = ($urandom_range(0, 19) == 0);
      continuous = $urandom_range(0, 1) == 1;
      ch_mask    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      dwell      = DWELL_W'($urandom_range(0, 4));
      step();
    end
    start = 0; stop = 1;
    step(3);
    stop = 0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
Sequential select generator that drives the 3-to-8 line decoder's x/y/z inputs. On a start pulse it sweeps an enabled subset of the 8 decoder channels in ascending order and holds each channel for a programmable dwell time. It supports single-sweep or continuous mode, abort on request, and one-cycle handshake pulses per channel and per sweep. Sits directly upstream of the decoder; its x/y/z feed the decoder's x/y/z (x = MSB).

Parameters:
DWELL_W, 8, width of dwell count input
CNT_W, 8, width of sweep counter (used only with DECODER_SCAN_STATUS_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  sweep request pulse; sampled only in IDLE
stop  input  1  abort request; honoured while busy
continuous  input  1  1 = wrap after last channel; latched at start accept
ch_mask  input  8  channel enable, bit i = channel i; latched at start accept
dwell  input  DWELL_W  cycles per channel, 0 treated as 1; latched at start accept
x  output  1  select bit 2 (MSB) to decoder
y  output  1  select bit 1 to decoder
z  output  1  select bit 0 to decoder
sel_valid  output  1  x/y/z address a live channel
ch_done  output  1  pulse in final dwell cycle of each channel
busy  output  1  sweep in progress
done  output  1  one-cycle pulse: sweep finished, stopped, or empty-mask start

Behaviour:
- Reset (async, rst_n=0): state IDLE; x,y,z,sel_valid,ch_done,busy,done = 0; latched config cleared. Takes effect immediately, including mid-sweep.
- x/y/z = 000 whenever sel_valid = 0.
- States: IDLE, DWELL, FINISH.
- IDLE, start=1, ch_mask!=0 (cycle T): latch config. T+1: DWELL on lowest enabled index; busy=1, sel_valid=1, {x,y,z}=index.
- IDLE, start=1, ch_mask==0: T+1 done=1 for one cycle; busy stays 0.
- DWELL: dwell counter loads max(dwell,1) on channel entry and decrements each cycle; last cycle asserts ch_done=1. Next cycle presents next higher enabled channel with no gap cycle (next-index search is combinational from latched mask).
- After highest enabled channel: continuous=0 -> FINISH; continuous=1 -> wrap to lowest enabled channel, no gap.
- FINISH: lasts one cycle; done=1, busy=0, sel_valid=0; then IDLE. A start in this cycle is ignored. The earliest accepted restart is the cycle after the done pulse.
- stop=1 while busy: next cycle FINISH. stop takes priority over channel advance. If stop coincides with the final dwell cycle, ch_done is suppressed that cycle.
- stop in IDLE is ignored. start while busy is ignored; changes on ch_mask/dwell/continuous while busy have no effect.
- Single channel enabled, continuous=1: that channel is held indefinitely; ch_done pulses every dwell period.

Optional Feature:
Macro DECODER_SCAN_STATUS_EN.
- Defined: adds output port sweep_cnt [CNT_W-1:0]. Reset 0; cleared at start accept. Increments by 1 at each completed sweep (wrap in continuous mode, or entry to FINISH from the last channel). Saturates at all-ones. Not incremented on stop.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single full sweep: ch_mask=8'hFF, dwell=2, continuous=0, start at T -> x/y/z = 0..7 each for 2 cycles from T+1 to T+16; ch_done at T+2,T+4,...,T+16; done at T+17.
- Sparse mask: ch_mask=8'b1010_0100, dwell=0 -> channels 2,5,7 for 1 cycle each at T+1..T+3; ch_done high T+1..T+3; done at T+4.
- Continuous with stop: ch_mask=8'h81, dwell=3, continuous=1, stop at T+10 -> sequence 0,0,0,7,7,7,0,0,0,7; FINISH/done at T+11; no ch_done at T+10; sweep_cnt=1 when the macro is defined.
- Empty mask: ch_mask=0, start -> done at T+1; busy, sel_valid never high.
- Ignored inputs: start pulsed at T+5 during the sweep, and mask changed during the sweep -> sequence unchanged; start in the FINISH cycle not accepted.
- Async reset: rst_n low mid-dwell on channel 5 -> all outputs 0 without a clock edge; after release, no activity until a new start.
